// File: rtl/cache_sweep_sequencer.sv
// Address sweep sequencer in front of the direct-mapped cache: base/stride/length/passes, one request in flight.
// Define SWEEP_CHECKSUM_EN to add a rotate-XOR checksum of every accepted response word.
module cache_sweep_sequencer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 13,
  parameter int LEN_W  = 16,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [PASS_W-1:0] cfg_passes,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic              rsp_hit,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [DATA_W-1:0] data_out
`ifdef SWEEP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} SweepState;

  SweepState state, nextState;

  logic [ADDR_W-1:0] baseReg, strideReg, curAddr;
  logic [LEN_W-1:0]  lenReg, accIdx, accIdxInc;
  logic [PASS_W-1:0] passesReg, passIdx;
  logic [PASS_W:0]   passIdxInc, passTarget;
  logic              startAccept, rspAccept, lastInPass, runEnd;

  assign req_addr = curAddr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // A response can land in the handshake cycle itself; ISSUE then advances exactly like WAIT would.
  always_comb begin
    nextState   = state;
    req_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    rspAccept   = 1'b0;
    startAccept = 1'b0;
    accIdxInc   = accIdx + LEN_W'(1);
    passIdxInc  = {1'b0, passIdx} + (PASS_W+1)'(1);
    passTarget  = (passesReg == '0) ? (PASS_W+1)'(1) : {1'b0, passesReg};
    lastInPass  = (accIdxInc == lenReg);
    runEnd      = lastInPass && (passIdxInc == passTarget);
    case (state)
      IDLE, DONE: begin
        done        = (state == DONE);
        startAccept = start;
        if (start) nextState = (cfg_len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        req_valid = 1'b1;
        busy      = 1'b1;
        if (req_ready) begin
          rspAccept = rsp_valid;
          if (rsp_valid) nextState = runEnd ? DONE : ISSUE;
          else           nextState = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (rsp_valid) begin
          rspAccept = 1'b1;
          nextState = runEnd ? DONE : ISSUE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Config latch, sweep position and per-run statistics; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      baseReg    <= '0;
      strideReg  <= '0;
      lenReg     <= '0;
      passesReg  <= '0;
      curAddr    <= '0;
      accIdx     <= '0;
      passIdx    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      data_out   <= '0;
`ifdef SWEEP_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else if (startAccept) begin
      baseReg    <= cfg_base;
      strideReg  <= cfg_stride;
      lenReg     <= cfg_len;
      passesReg  <= cfg_passes;
      curAddr    <= cfg_base;
      accIdx     <= '0;
      passIdx    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
`ifdef SWEEP_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else if (rspAccept) begin
      if (rsp_hit) begin
        if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
      end
      data_out <= rsp_data;
`ifdef SWEEP_CHECKSUM_EN
      checksum <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ rsp_data;
`endif
      if (lastInPass) begin
        accIdx  <= '0;
        passIdx <= passIdx + PASS_W'(1);
        curAddr <= baseReg;
      end else begin
        accIdx  <= accIdxInc;
        curAddr <= curAddr + strideReg;
      end
    end
  end

endmodule
